// File: rtl/bcd_multi_counter.sv
// bcd_multi_counter: multi-digit up/down counter with a per-digit radix of
// DIGIT_MAX+1. Digits are packed 4 bits each, digit 0 least significant.
// A programmable step is applied at digit 0 and carries/borrows ripple
// through the higher digits within one cycle. When the top digit carries or
// borrows out, the counter either wraps or clamps (SATURATE), and a
// registered one-cycle overflow/underflow pulse is raised.
module bcd_multi_counter #(
  parameter int NUM_DIGITS = 3,
  parameter int DIGIT_MAX  = 9,
  parameter int SATURATE   = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] datain,
  input  logic                    enable1,
  input  logic                    enable2,
  input  logic                    enable3,
  input  logic                    up_down,
  input  logic [3:0]              step,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic                    tc_max,
  output logic                    tc_min,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int          W     = 4 * NUM_DIGITS;
  localparam logic [3:0]  DMAX4 = 4'(DIGIT_MAX);
  localparam logic [4:0]  DMAX5 = 5'(DIGIT_MAX);
  localparam logic [4:0]  RADIX = 5'(DIGIT_MAX + 1);

  logic [W-1:0] r_count;
  logic         r_overflow;
  logic         r_underflow;

  logic [3:0]   w_step;
  logic         w_count_en;
  logic [W-1:0] w_load_val;
  logic [W-1:0] w_all_max;
  logic [W-1:0] w_inc;
  logic [W-1:0] w_dec;
  logic         w_carry_out;
  logic         w_borrow_out;

  // A step larger than one digit can hold is treated as DIGIT_MAX.
  assign w_step     = (step > DMAX4) ? DMAX4 : step;
  assign w_count_en = enable1 & enable2 & enable3 & (w_step != 4'd0);

  // Load value with out-of-range digits clamped, plus the all-max constant.
  always_comb begin
    w_load_val = '0;
    w_all_max  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_load_val[4*i +: 4] = (datain[4*i +: 4] > DMAX4) ? DMAX4 : datain[4*i +: 4];
      w_all_max[4*i +: 4]  = DMAX4;
    end
  end

  // Up path: add the step at digit 0 and ripple a single-bit carry upward.
  // Both operands are <= DIGIT_MAX, so one subtraction of the radix suffices.
  always_comb begin
    logic [4:0] v_add;
    logic [4:0] v_sum;
    logic [4:0] v_res;
    logic       v_c;
    w_inc = '0;
    v_c   = 1'b0;
    v_add = '0;
    v_sum = '0;
    v_res = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      v_add = (i == 0) ? {1'b0, w_step} : {4'd0, v_c};
      v_sum = {1'b0, r_count[4*i +: 4]} + v_add;
      if (v_sum > DMAX5) begin
        v_res = v_sum - RADIX;
        v_c   = 1'b1;
      end else begin
        v_res = v_sum;
        v_c   = 1'b0;
      end
      w_inc[4*i +: 4] = v_res[3:0];
    end
    w_carry_out = v_c;
  end

  // Down path: subtract the step at digit 0 and ripple a borrow upward.
  always_comb begin
    logic [4:0] v_sub;
    logic [4:0] v_dig;
    logic [4:0] v_res;
    logic       v_b;
    w_dec = '0;
    v_b   = 1'b0;
    v_sub = '0;
    v_dig = '0;
    v_res = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      v_sub = (i == 0) ? {1'b0, w_step} : {4'd0, v_b};
      v_dig = {1'b0, r_count[4*i +: 4]};
      if (v_dig < v_sub) begin
        v_res = v_dig + RADIX - v_sub;
        v_b   = 1'b1;
      end else begin
        v_res = v_dig - v_sub;
        v_b   = 1'b0;
      end
      w_dec[4*i +: 4] = v_res[3:0];
    end
    w_borrow_out = v_b;
  end

  // Count register and flag pulses: reset > load > count > hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (load) begin
      r_count     <= w_load_val;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (w_count_en && up_down) begin
      r_underflow <= 1'b0;
      r_overflow  <= w_carry_out;
      if (w_carry_out && (SATURATE != 0)) begin
        r_count <= w_all_max;
      end else begin
        r_count <= w_inc;
      end
    end else if (w_count_en) begin
      r_overflow  <= 1'b0;
      r_underflow <= w_borrow_out;
      if (w_borrow_out && (SATURATE != 0)) begin
        r_count <= '0;
      end else begin
        r_count <= w_dec;
      end
    end else begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end
  end

  assign count     = r_count;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;
  assign tc_max    = (r_count == w_all_max);
  assign tc_min    = (r_count == '0);

endmodule

// File: tb/tb_bcd_multi_counter.sv
// tb_bcd_multi_counter: directed vectors against three configurations of
// bcd_multi_counter: 3-digit decimal wrap, 3-digit decimal saturate, and a
// 1-digit radix-6 wrap counter.
module tb_bcd_multi_counter;

  logic        clk;
  logic        reset;
  logic        load;
  logic [11:0] datain;
  logic        en1, en2, en3;
  logic        up_down;
  logic [3:0]  step;

  logic [11:0] cnt_w, cnt_s;
  logic        tmax_w, tmin_w, ovf_w, unf_w;
  logic        tmax_s, tmin_s, ovf_s, unf_s;

  logic        s_load;
  logic [3:0]  s_datain;
  logic        s_en;
  logic        s_up;
  logic [3:0]  s_step;
  logic [3:0]  cnt_1;
  logic        tmax_1, tmin_1, ovf_1, unf_1;

  int checks;
  int failures;

  bcd_multi_counter #(.NUM_DIGITS(3), .DIGIT_MAX(9), .SATURATE(0)) u_wrap (
    .clk(clk), .reset(reset), .load(load), .datain(datain),
    .enable1(en1), .enable2(en2), .enable3(en3), .up_down(up_down), .step(step),
    .count(cnt_w), .tc_max(tmax_w), .tc_min(tmin_w), .overflow(ovf_w), .underflow(unf_w)
  );

  bcd_multi_counter #(.NUM_DIGITS(3), .DIGIT_MAX(9), .SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .load(load), .datain(datain),
    .enable1(en1), .enable2(en2), .enable3(en3), .up_down(up_down), .step(step),
    .count(cnt_s), .tc_max(tmax_s), .tc_min(tmin_s), .overflow(ovf_s), .underflow(unf_s)
  );

  bcd_multi_counter #(.NUM_DIGITS(1), .DIGIT_MAX(5), .SATURATE(0)) u_small (
    .clk(clk), .reset(reset), .load(s_load), .datain(s_datain),
    .enable1(s_en), .enable2(s_en), .enable3(s_en), .up_down(s_up), .step(s_step),
    .count(cnt_1), .tc_max(tmax_1), .tc_min(tmin_1), .overflow(ovf_1), .underflow(unf_1)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparison point
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [11:0] d);
    load = 1'b1;
    datain = d;
    {en1, en2, en3} = 3'b000;
    tick();
    load = 1'b0;
  endtask

  task automatic count_step(input logic ud, input logic [3:0] st);
    up_down = ud;
    step = st;
    {en1, en2, en3} = 3'b111;
    tick();
    {en1, en2, en3} = 3'b000;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    load = 1'b0;
    datain = '0;
    {en1, en2, en3} = 3'b000;
    up_down = 1'b1;
    step = 4'd1;
    s_load = 1'b0;
    s_datain = '0;
    s_en = 1'b0;
    s_up = 1'b1;
    s_step = 4'd1;

    #2;
    check("reset_count", 32'(cnt_w), 32'h000);
    check("reset_tc_min", 32'(tmin_w), 32'd1);
    check("reset_tc_max", 32'(tmax_w), 32'd0);
    check("reset_flags", 32'({ovf_w, unf_w}), 32'd0);
    #10;
    reset = 1'b0;

    // Reset asserted mid-count clears without a clock edge
    do_load(12'h057);
    check("load_057", 32'(cnt_w), 32'h057);
    up_down = 1'b1;
    step = 4'd1;
    {en1, en2, en3} = 3'b111;
    tick();
    check("count_058", 32'(cnt_w), 32'h058);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_count", 32'(cnt_w), 32'h000);
    check("async_reset_tc_min", 32'(tmin_w), 32'd1);
    #1;
    reset = 1'b0;
    tick();
    check("first_after_reset", 32'(cnt_w), 32'h001);
    {en1, en2, en3} = 3'b000;

    // Ripple carry
    do_load(12'h199);
    count_step(1'b1, 4'd1);
    check("ripple_199_to_200", 32'(cnt_w), 32'h200);
    check("ripple_no_flag", 32'({ovf_w, unf_w}), 32'd0);
    do_load(12'h095);
    count_step(1'b1, 4'd7);
    check("ripple_095_plus7", 32'(cnt_w), 32'h102);

    // Top-digit carry: wrap vs saturate
    do_load(12'h998);
    count_step(1'b1, 4'd5);
    check("wrap_998_plus5", 32'(cnt_w), 32'h003);
    check("wrap_ovf", 32'(ovf_w), 32'd1);
    check("sat_998_plus5", 32'(cnt_s), 32'h999);
    check("sat_ovf", 32'(ovf_s), 32'd1);
    tick();
    check("wrap_ovf_one_cycle", 32'(ovf_w), 32'd0);
    check("wrap_hold_003", 32'(cnt_w), 32'h003);

    // Top-digit borrow
    do_load(12'h002);
    count_step(1'b0, 4'd4);
    check("wrap_002_minus4", 32'(cnt_w), 32'h998);
    check("wrap_unf", 32'({ovf_w, unf_w}), 32'b01);
    check("sat_002_minus4", 32'(cnt_s), 32'h000);
    check("sat_unf", 32'({ovf_s, unf_s}), 32'b01);
    tick();
    check("wrap_unf_one_cycle", 32'(unf_w), 32'd0);

    // Saturate at the limit re-pulses
    do_load(12'h996);
    count_step(1'b1, 4'd9);
    check("sat_996_plus9", 32'(cnt_s), 32'h999);
    check("sat_ovf_996", 32'(ovf_s), 32'd1);
    check("wrap_996_plus9", 32'(cnt_w), 32'h005);
    count_step(1'b1, 4'd9);
    check("sat_hold_999", 32'(cnt_s), 32'h999);
    check("sat_ovf_again", 32'(ovf_s), 32'd1);
    check("sat_tc_max", 32'({tmax_s, tmin_s}), 32'b10);
    check("wrap_005_plus9", 32'(cnt_w), 32'h014);
    check("wrap_no_ovf", 32'(ovf_w), 32'd0);
    do_load(12'h003);
    count_step(1'b0, 4'd5);
    check("sat_003_minus5", 32'(cnt_s), 32'h000);
    check("sat_unf_003", 32'(unf_s), 32'd1);
    check("sat_tc_min", 32'({tmax_s, tmin_s}), 32'b01);
    count_step(1'b0, 4'd1);
    check("sat_hold_000", 32'(cnt_s), 32'h000);
    check("sat_unf_again", 32'(unf_s), 32'd1);

    // Load priority over counting, with digit clamp
    load = 1'b1;
    datain = 12'hF3A;
    {en1, en2, en3} = 3'b111;
    up_down = 1'b1;
    step = 4'd1;
    tick();
    load = 1'b0;
    {en1, en2, en3} = 3'b000;
    check("load_clamp_F3A", 32'(cnt_w), 32'h939);
    check("load_no_flags", 32'({ovf_w, unf_w}), 32'd0);

    // Any enable low holds
    {en1, en2, en3} = 3'b011;
    tick();
    check("hold_en1_low", 32'(cnt_w), 32'h939);
    {en1, en2, en3} = 3'b101;
    tick();
    check("hold_en2_low", 32'(cnt_w), 32'h939);
    {en1, en2, en3} = 3'b110;
    tick();
    check("hold_en3_low", 32'(cnt_w), 32'h939);
    {en1, en2, en3} = 3'b000;

    // Step clamp and zero step
    do_load(12'h100);
    count_step(1'b1, 4'd12);
    check("step12_as_9", 32'(cnt_w), 32'h109);
    count_step(1'b1, 4'd0);
    check("step0_hold", 32'(cnt_w), 32'h109);
    check("step0_no_flags", 32'({ovf_w, unf_w}), 32'd0);
    count_step(1'b0, 4'd15);
    check("step15_down_as_9", 32'(cnt_w), 32'h100);

    // Single-digit radix-6 counter: 1,2,3,4,5,0,1 from 0
    check("small_start", 32'(cnt_1), 32'd0);
    s_up = 1'b1;
    s_step = 4'd1;
    s_en = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      check("small_count", 32'(cnt_1), 32'(i % 6));
      check("small_ovf", 32'(ovf_1), (i == 6) ? 32'd1 : 32'd0);
      check("small_tc_max", 32'(tmax_1), (i == 5) ? 32'd1 : 32'd0);
    end
    s_up = 1'b0;
    tick();
    check("small_down_0", 32'(cnt_1), 32'd0);
    tick();
    check("small_down_wrap", 32'(cnt_1), 32'd5);
    check("small_unf", 32'({ovf_1, unf_1}), 32'b01);
    s_en = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety timeout
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
